// File: rtl/modinv_sched_pkg.sv
// Shared definitions for the modular-inverse helper sequencer:
// phase FSM encoding, iteration-counter sizing and the watchdog bound.
package modinv_sched_pkg;

  // One-hot phase encoding of the top-level sequencer
  typedef enum logic [6:0] {
    ST_IDLE       = 7'b000_0001,
    ST_INIT_TRIG  = 7'b000_0010,
    ST_INIT_WAIT  = 7'b000_0100,
    ST_STEP_TRIG  = 7'b000_1000,
    ST_STEP_WAIT  = 7'b001_0000,
    ST_FINAL_TRIG = 7'b010_0000,
    ST_FINAL_WAIT = 7'b100_0000
  } sched_state_t;

  // Index of each helper in the handshake-unit vectors
  localparam int HS_INIT  = 0;
  localparam int HS_STEP  = 1;
  localparam int HS_FINAL = 2;
  localparam int HS_COUNT = 3;

  // Ceiling log2, usable in constant (parameter) expressions
  function automatic int modinv_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Upper bound on almost-inverse iterations for an operand of 'words' 32-bit words
  function automatic int MODINV_MAX_ITER(input int words);
    return 2 * words * 32;
  endfunction

  // Width needed to hold 0..MODINV_MAX_ITER(words)
  function automatic int modinv_k_bits(input int words);
    return modinv_clog2(MODINV_MAX_ITER(words) + 1);
  endfunction

endpackage

// File: rtl/modinv_sched_hs.sv
// TRIG/guard/WAIT handshake unit for one helper.
// The enable pulse is decoded from the parent's TRIG phase; the guard bit
// masks the first WAIT cycle, where the helper's rdy has not yet dropped.
module modinv_sched_hs (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,        // parent FSM is in this helper's TRIG phase
  input  logic waiting,     // parent FSM is in this helper's WAIT phase
  input  logic helper_rdy,  // helper idle
  output logic helper_ena,  // one-cycle start pulse to the helper
  output logic done         // helper finished (strobe to the parent FSM)
);

  logic guard_reg;

  // Guard is set for exactly the cycle following TRIG
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_reg <= 1'b0;
    end else begin
      guard_reg <= trig;
    end
  end

  assign helper_ena = trig;
  assign done       = waiting & ~guard_reg & helper_rdy;

endmodule

// File: rtl/modinv_helper_sched.sv
// Top-level sequencer for the modular invertor's helper datapath:
// init once, step until the step helper reports u==0, then final correction.
// Counts completed step iterations in k.
// Optional feature: define MODINV_SCHED_WATCHDOG_EN to add an iteration
// watchdog and the err output.
module modinv_helper_sched
  import modinv_sched_pkg::*;
#(
  parameter int OPERAND_NUM_WORDS = 8,
  parameter int K_BITS            = modinv_k_bits(OPERAND_NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  output logic              rdy,
  output logic              init_ena,
  input  logic              init_rdy,
  output logic              step_ena,
  input  logic              step_rdy,
  input  logic              step_done,
  output logic              final_ena,
  input  logic              final_rdy,
  output logic [K_BITS-1:0] k
`ifdef MODINV_SCHED_WATCHDOG_EN
  ,
  output logic              err
`endif
);

  localparam logic [K_BITS-1:0] K_MAX = '1;
`ifdef MODINV_SCHED_WATCHDOG_EN
  localparam logic [K_BITS-1:0] WD_LIMIT = K_BITS'(MODINV_MAX_ITER(OPERAND_NUM_WORDS));
  logic err_reg;
`endif

  sched_state_t       state_reg;
  logic [K_BITS-1:0]  k_reg;
  logic [K_BITS-1:0]  k_next;

  logic [HS_COUNT-1:0] trig_vec;
  logic [HS_COUNT-1:0] wait_vec;
  logic [HS_COUNT-1:0] hrdy_vec;
  logic [HS_COUNT-1:0] hena_vec;
  logic [HS_COUNT-1:0] done_vec;

  // Saturating increment: k never wraps back to zero
  assign k_next = (k_reg == K_MAX) ? k_reg : k_reg + 1'b1;

  assign trig_vec = {state_reg == ST_FINAL_TRIG, state_reg == ST_STEP_TRIG, state_reg == ST_INIT_TRIG};
  assign wait_vec = {state_reg == ST_FINAL_WAIT, state_reg == ST_STEP_WAIT, state_reg == ST_INIT_WAIT};
  assign hrdy_vec = {final_rdy, step_rdy, init_rdy};

  genvar gi;
  generate
    for (gi = 0; gi < HS_COUNT; gi++) begin : g_hs
      modinv_sched_hs u_hs (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig_vec[gi]),
        .waiting    (wait_vec[gi]),
        .helper_rdy (hrdy_vec[gi]),
        .helper_ena (hena_vec[gi]),
        .done       (done_vec[gi])
      );
    end
  endgenerate

  // Phase FSM, iteration counter and (optionally) the watchdog abort flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
`ifdef MODINV_SCHED_WATCHDOG_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ena) begin
            state_reg <= ST_INIT_TRIG;
            k_reg     <= '0;
`ifdef MODINV_SCHED_WATCHDOG_EN
            err_reg   <= 1'b0;
`endif
          end
        end
        ST_INIT_TRIG: state_reg <= ST_INIT_WAIT;
        ST_INIT_WAIT: begin
          if (done_vec[HS_INIT]) begin
            state_reg <= ST_STEP_TRIG;
          end
        end
        ST_STEP_TRIG: state_reg <= ST_STEP_WAIT;
        ST_STEP_WAIT: begin
          if (done_vec[HS_STEP]) begin
            k_reg <= k_next;
            if (step_done) begin
              state_reg <= ST_FINAL_TRIG;
`ifdef MODINV_SCHED_WATCHDOG_EN
            end else if (k_next > WD_LIMIT) begin
              // Runaway loop: abandon the operation and skip the final helper
              state_reg <= ST_IDLE;
              err_reg   <= 1'b1;
`endif
            end else begin
              state_reg <= ST_STEP_TRIG;
            end
          end
        end
        ST_FINAL_TRIG: state_reg <= ST_FINAL_WAIT;
        ST_FINAL_WAIT: begin
          if (done_vec[HS_FINAL]) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rdy       = (state_reg == ST_IDLE);
  assign init_ena  = hena_vec[HS_INIT];
  assign step_ena  = hena_vec[HS_STEP];
  assign final_ena = hena_vec[HS_FINAL];
  assign k         = k_reg;
`ifdef MODINV_SCHED_WATCHDOG_EN
  assign err       = err_reg;
`endif

endmodule
